// File: rtl/mcu_strip_reader_if.sv
// Pixel stream from the strip reader to the DCT stage.
// The master drives the data and flags; the slave returns ready.
interface mcu_strip_reader_if;
    logic [7:0] pixel;
    logic       valid;
    logic       ready;
    logic       mcu_first;
    logic       strip_last;

    modport master (
        output pixel,
        output valid,
        output mcu_first,
        output strip_last,
        input  ready
    );

    modport slave (
        input  pixel,
        input  valid,
        input  mcu_first,
        input  strip_last,
        output ready
    );
endinterface

// File: rtl/mcu_strip_reader.sv
// Drains one completed 8-line strip (40 MCUs x 64 pixels) from the ingester's back buffer
// and emits it as a level-shifted, MCU-ordered valid/ready pixel stream.
module mcu_strip_reader #(
    parameter int unsigned NUM_EBRS     = 5,
    parameter int unsigned MCUS_PER_EBR = 8,
    parameter bit          LEVEL_SHIFT  = 1'b1
) (
    input  logic                  i_clock,
    input  logic                  i_nreset,
    input  logic                  i_frontbuffer_select,
    output logic                  o_read_buffer_select,
    output logic                  o_read_en,
    output logic [8:0]            o_read_addr,
    input  logic [8*NUM_EBRS-1:0] i_ebr_rdata,
    output logic                  o_busy,
    output logic                  o_overrun,
    mcu_strip_reader_if.master    o_strm
);

    localparam int unsigned EbrW  = (NUM_EBRS > 1) ? $clog2(NUM_EBRS) : 1;
    localparam int unsigned SlotW = (MCUS_PER_EBR > 1) ? $clog2(MCUS_PER_EBR) : 1;
    localparam logic [EbrW-1:0]  LastEbr  = EbrW'(NUM_EBRS - 1);
    localparam logic [SlotW-1:0] LastSlot = SlotW'(MCUS_PER_EBR - 1);

    typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

    state_e           r_state, w_state_nxt;
    logic             r_fb_prev;
    logic             r_armed;
    logic             w_start;
    logic [5:0]       r_pix;
    logic [EbrW-1:0]  r_ebr;
    logic [SlotW-1:0] r_slot;
    logic             w_credit_ok;
    logic             w_issue;
    logic             w_last_issue;
    logic [2:0]       w_occ;

    logic             r_rd_vld;
    logic             r_rd_first;
    logic             r_rd_last;
    logic [EbrW-1:0]  r_rd_ebr;
    logic [7:0]       w_rd_byte;
    logic [7:0]       w_push_pixel;

    logic [9:0]       r_fifo_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_cnt;
    logic             w_push;
    logic             w_pop;
    logic [9:0]       w_head;

    // r_armed masks the first cycle after reset so the detector can settle on the input.
    assign w_start = r_armed && (i_frontbuffer_select != r_fb_prev);

    always_ff @(posedge i_clock or negedge i_nreset) begin
        if (!i_nreset) begin
            r_fb_prev <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_fb_prev <= i_frontbuffer_select;
            r_armed   <= 1'b1;
        end
    end

    // A pop this cycle frees a slot by the time the new read lands, keeping full rate.
    assign w_occ        = {1'b0, r_cnt} + {2'b00, r_rd_vld};
    assign w_credit_ok  = w_occ < (3'd2 + {2'b00, w_pop});
    assign w_issue      = (r_state == StRead) && w_credit_ok;
    assign w_last_issue = w_issue && (r_pix == 6'd63) && (r_ebr == LastEbr)
                          && (r_slot == LastSlot);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (w_start) w_state_nxt = StRead;
            StRead:  if (w_last_issue) w_state_nxt = StDrain;
            StDrain: if ((r_cnt == 2'd0) && !r_rd_vld) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_nreset) begin
        if (!i_nreset) begin
            r_state              <= StIdle;
            o_read_buffer_select <= 1'b0;
            o_overrun            <= 1'b0;
            r_pix                <= '0;
            r_ebr                <= '0;
            r_slot               <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start && (r_state != StIdle)) begin
                o_overrun <= 1'b1;
            end
            if ((r_state == StIdle) && w_start) begin
                o_read_buffer_select <= ~i_frontbuffer_select;
                r_pix                <= '0;
                r_ebr                <= '0;
                r_slot               <= '0;
            end else if (w_issue) begin
                r_pix <= r_pix + 6'd1;
                if (r_pix == 6'd63) begin
                    if (r_ebr == LastEbr) begin
                        r_ebr  <= '0;
                        r_slot <= r_slot + SlotW'(1);
                    end else begin
                        r_ebr <= r_ebr + EbrW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_nreset) begin
        if (!i_nreset) begin
            r_rd_vld   <= 1'b0;
            r_rd_first <= 1'b0;
            r_rd_last  <= 1'b0;
            r_rd_ebr   <= '0;
        end else begin
            r_rd_vld   <= w_issue;
            r_rd_first <= (r_pix == 6'd0);
            r_rd_last  <= w_last_issue;
            r_rd_ebr   <= r_ebr;
        end
    end

    // Only the addressed EBR's byte is ever routed; the other douts may hold anything.
    always_comb begin
        w_rd_byte = 8'h00;
        for (int unsigned k = 0; k < NUM_EBRS; k++) begin
            if (r_rd_ebr == EbrW'(k)) w_rd_byte = i_ebr_rdata[8*k +: 8];
        end
    end

    assign w_push_pixel = LEVEL_SHIFT ? {~w_rd_byte[7], w_rd_byte[6:0]} : w_rd_byte;
    assign w_push       = r_rd_vld;
    assign w_pop        = (r_cnt != 2'd0) && o_strm.ready;

    always_ff @(posedge i_clock or negedge i_nreset) begin
        if (!i_nreset) begin
            r_fifo_mem[0] <= '0;
            r_fifo_mem[1] <= '0;
            r_wptr        <= 1'b0;
            r_rptr        <= 1'b0;
            r_cnt         <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_mem[r_wptr] <= {r_rd_last, r_rd_first, w_push_pixel};
                r_wptr             <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign w_head = r_fifo_mem[r_rptr];

    assign o_strm.valid      = (r_cnt != 2'd0);
    assign o_strm.pixel      = o_strm.valid ? w_head[7:0] : 8'h00;
    assign o_strm.mcu_first  = o_strm.valid & w_head[8];
    assign o_strm.strip_last = o_strm.valid & w_head[9];

    assign o_read_en   = w_issue;
    assign o_read_addr = 9'({r_slot, r_pix});
    assign o_busy      = (r_state != StIdle);

endmodule
